fp_normalize_round: RTL and testbench

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

---
 rtl/fp_normalize_round.sv | 208 ++++++++++++++++++++
 tb/tb_fp_normalize_round.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round.sv
// Normalize and round stage for a single-precision adder.
// Takes the raw sum, exponent and guard/round/sticky bits from the alignment/add
// stage. It renormalizes the sum, rounds to nearest-even and packs an IEEE-754
// single. Infinity saturates with overflow. Results that fall below the normal
// range are flushed to signed zero with underflow.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_valid/in_ready accept one operand only in IDLE; there is no buffering.
// out_valid rises in DONE. result/overflow/underflow then stay unchanged until
// out_ready is seen high, and the block returns to IDLE on that edge.
module fp_normalize_round #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sign_in,
   input  logic [EXP_W-1:0]   exponent_in,
   input  logic [MAN_W+1:0]   sum_mantissa,
   input  logic [2:0]         grs_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        result,
   output logic               overflow,
   output logic               underflow,
   output logic [2:0]         debug_state
);

   // One extra exponent bit so increments past the max exponent are visible.
   localparam int XW = EXP_W + 1;
   localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [XW-1:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
   localparam logic [XW-1:0] EXP_ZERO = '0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      SHIFT = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state, state_n;
   logic              sign_r;
   logic [XW-1:0]     exp_r, exp_n;
   logic [MAN_W+1:0]  man_r, man_n;
   logic              guard_r, guard_n;
   logic              round_r, round_n;
   logic              sticky_r, sticky_n;
   logic              sign_n;
   logic [31:0]       result_r, result_n;
   logic              overflow_r, overflow_n;
   logic              underflow_r, underflow_n;

   // Scratch values for the carry and rounding paths.
   logic [MAN_W+1:0]  man_sum;
   logic [XW-1:0]     exp_inc;
   logic              rnd_inc;

   assign in_ready    = (state == IDLE) && !reset;
   assign out_valid   = (state == DONE);
   assign result      = result_r;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;
   assign debug_state = state;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state and next-datapath logic for every FSM state.
   always_comb begin
      state_n     = state;
      sign_n      = sign_r;
      exp_n       = exp_r;
      man_n       = man_r;
      guard_n     = guard_r;
      round_n     = round_r;
      sticky_n    = sticky_r;
      result_n    = result_r;
      overflow_n  = overflow_r;
      underflow_n = underflow_r;
      man_sum     = '0;
      exp_inc     = '0;
      rnd_inc     = 1'b0;

      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_n   = sign_in;
               exp_n    = {1'b0, exponent_in};
               man_n    = sum_mantissa;
               guard_n  = grs_in[2];
               round_n  = grs_in[1];
               sticky_n = grs_in[0];
               state_n  = CHECK;
            end
         end

         CHECK: begin
            overflow_n  = 1'b0;
            underflow_n = 1'b0;
            if (man_r == '0 && {guard_r, round_r, sticky_r} == 3'b000) begin
               result_n = 32'({sign_r, {(EXP_W + MAN_W){1'b0}}});
               state_n  = DONE;
            end else if (exp_r == EXP_ZERO) begin
               result_n    = 32'({sign_r, {(EXP_W + MAN_W){1'b0}}});
               underflow_n = 1'b1;
               state_n     = DONE;
            end else if (exp_r == EXP_MAX) begin
               // No NaN support: a max-exponent operand saturates.
               result_n   = 32'({sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}});
               overflow_n = 1'b1;
               state_n    = DONE;
            end else if (man_r[MAN_W+1]) begin
               // Carry out of the add: shift right, fold round into sticky.
               man_n    = man_r >> 1;
               guard_n  = man_r[0];
               round_n  = guard_r;
               sticky_n = round_r | sticky_r;
               exp_inc  = exp_r + EXP_ONE;
               exp_n    = exp_inc;
               if (exp_inc >= EXP_MAX) begin
                  result_n   = 32'({sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}});
                  overflow_n = 1'b1;
                  state_n    = DONE;
               end else begin
                  state_n = ROUND;
               end
            end else if (man_r[MAN_W]) begin
               state_n = ROUND;
            end else begin
               state_n = SHIFT;
            end
         end

         SHIFT: begin
            if (exp_r == EXP_ONE && !man_r[MAN_W]) begin
               // Any further left shift would need a denormal; flush instead.
               result_n    = 32'({sign_r, {(EXP_W + MAN_W){1'b0}}});
               underflow_n = 1'b1;
               state_n     = DONE;
            end else begin
               man_n   = {man_r[MAN_W:0], guard_r};
               guard_n = round_r;
               round_n = 1'b0;
               exp_n   = exp_r - EXP_ONE;
               if (man_n[MAN_W]) state_n = ROUND;
            end
         end

         ROUND: begin
            rnd_inc = guard_r & (round_r | sticky_r | man_r[0]);
            man_sum = man_r + {{(MAN_W + 1){1'b0}}, rnd_inc};
            exp_inc = exp_r;
            if (man_sum[MAN_W+1]) begin
               man_sum = man_sum >> 1;
               exp_inc = exp_r + EXP_ONE;
            end
            man_n = man_sum;
            exp_n = exp_inc;
            if (exp_inc >= EXP_MAX) begin
               result_n   = 32'({sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}});
               overflow_n = 1'b1;
            end else begin
               result_n = 32'({sign_r, exp_inc[EXP_W-1:0], man_sum[MAN_W-1:0]});
            end
            state_n = DONE;
         end

         DONE: begin
            if (out_ready) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   // Captured operand, working registers and result/flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sign_r      <= 1'b0;
         exp_r       <= '0;
         man_r       <= '0;
         guard_r     <= 1'b0;
         round_r     <= 1'b0;
         sticky_r    <= 1'b0;
         result_r    <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         sign_r      <= sign_n;
         exp_r       <= exp_n;
         man_r       <= man_n;
         guard_r     <= guard_n;
         round_r     <= round_n;
         sticky_r    <= sticky_n;
         result_r    <= result_n;
         overflow_r  <= overflow_n;
         underflow_r <= underflow_n;
      end
   end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vectors, a reference model for random
// operands, backpressure and reset-abort scenarios.
module tb_fp_normalize_round;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [7:0]  exponent_in;
   logic [24:0] sum_mantissa;
   logic [2:0]  grs_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic [2:0]  debug_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Expected entry: {latency[7:0], overflow, underflow, result[31:0]}; latency 8'hFF = unchecked.
   logic [41:0] exp_q[$];
   int          acc_q[$];
   bit          seen = 1'b0;

   fp_normalize_round dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sign_in      (sign_in),
      .exponent_in  (exponent_in),
      .sum_mantissa (sum_mantissa),
      .grs_in       (grs_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .overflow     (overflow),
      .underflow    (underflow),
      .debug_state  (debug_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [41:0] mk(input logic [31:0] r, input logic o, input logic u, input int lat);
      return {8'(lat), o, u, r};
   endfunction

   // Reference for operands that need no left shift: exact value {m,g}, round to nearest-even.
   function automatic logic [41:0] model_norm(input logic s, input logic [7:0] e,
                                              input logic [24:0] m, input logic [2:0] g);
      int v, drop, kept, rem, half, ex;
      logic up;
      v    = int'({m, g});
      drop = m[24] ? 4 : 3;
      ex   = int'(e) + (m[24] ? 1 : 0);
      if (m[24] && ex >= 255) return mk({s, 8'hFF, 23'h0}, 1'b1, 1'b0, 2);
      kept = v >> drop;
      rem  = v & ((1 << drop) - 1);
      half = 1 << (drop - 1);
      up   = (rem > half) || (rem == half && kept[0]);
      kept = kept + int'(up);
      if (kept >= (1 << 24)) begin
         kept = kept >> 1;
         ex   = ex + 1;
      end
      if (ex >= 255) return mk({s, 8'hFF, 23'h0}, 1'b1, 1'b0, 3);
      return mk({s, 8'(ex), 23'(kept)}, 1'b0, 1'b0, 3);
   endfunction

   // Scoreboard: pop and compare on the first cycle of each out_valid pulse.
   always @(negedge clk) begin
      logic [41:0] e;
      int a, lat;
      if (out_valid && !seen) begin
         seen = 1'b1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got result=%h with nothing expected", result);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            if ({overflow, underflow, result} !== e[33:0]) begin
               errors++;
               $display("FAIL result: got ovf=%b unf=%b res=%h, expected ovf=%b unf=%b res=%h",
                        overflow, underflow, result, e[33], e[32], e[31:0]);
            end
            if (e[41:34] != 8'hFF) begin
               lat = cyc - a + 1;
               checks++;
               if (lat != int'(e[41:34])) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles, expected %0d (res=%h)", lat, e[41:34], e[31:0]);
               end
            end
         end
      end else if (!out_valid) begin
         seen = 1'b0;
      end
   end

   // Driver: present one operand, optionally expect a result, optionally wait for completion.
   task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [2:0] g,
                       input logic [41:0] expv, input bit push, input bit wait_done);
      int t;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
         return;
      end
      sign_in      = s;
      exponent_in  = e;
      sum_mantissa = m;
      grs_in       = g;
      in_valid     = 1'b1;
      if (push) exp_q.push_back(expv);
      @(posedge clk);
      #1;
      if (push) acc_q.push_back(cyc);
      in_valid = 1'b0;
      if (wait_done) begin
         t = 0;
         while (!(out_valid && out_ready) && t < 100) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (!(out_valid && out_ready)) begin
            errors++;
            $display("FAIL done_timeout: out_valid=%b, expected 1", out_valid);
         end else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      sign_in = 1'b0;
      exponent_in = '0;
      sum_mantissa = '0;
      grs_in = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 0 0", in_ready, out_valid);
      end
      checks++;
      if (result !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0 || debug_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: res=%h ovf=%b unf=%b st=%0d, expected 0 0 0 0",
                  result, overflow, underflow, debug_state);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b, expected 1", in_ready);
      end
   endtask

   task automatic test_normalize();
      send(1'b0, 8'd127, 25'h0800000, 3'b000, mk(32'h3F800000, 0, 0, 3), 1, 1);
      send(1'b0, 8'd127, 25'h1000000, 3'b000, mk(32'h40000000, 0, 0, 3), 1, 1);
      send(1'b1, 8'd150, 25'h0000001, 3'b000, mk(32'hBF800000, 0, 0, 26), 1, 1);
      send(1'b0, 8'd130, 25'h0000000, 3'b100, mk(32'h35000000, 0, 0, 27), 1, 1);
      send(1'b0, 8'd100, 25'h0000000, 3'b000, mk(32'h00000000, 0, 0, 2), 1, 1);
      send(1'b1, 8'd100, 25'h0000000, 3'b000, mk(32'h80000000, 0, 0, 2), 1, 1);
   endtask

   task automatic test_round();
      send(1'b0, 8'd127, 25'h0FFFFFF, 3'b100, mk(32'h40000000, 0, 0, 3), 1, 1);
      send(1'b0, 8'd127, 25'h0800000, 3'b100, mk(32'h3F800000, 0, 0, 3), 1, 1);
      send(1'b0, 8'd127, 25'h0800001, 3'b100, mk(32'h3F800002, 0, 0, 3), 1, 1);
      send(1'b0, 8'd127, 25'h1000001, 3'b000, mk(32'h40000000, 0, 0, 3), 1, 1);
      send(1'b0, 8'd127, 25'h1000003, 3'b000, mk(32'h40000002, 0, 0, 3), 1, 1);
   endtask

   task automatic test_overflow();
      send(1'b0, 8'd254, 25'h1000000, 3'b000, mk(32'h7F800000, 1, 0, 2), 1, 1);
      send(1'b1, 8'd254, 25'h0FFFFFF, 3'b110, mk(32'hFF800000, 1, 0, 3), 1, 1);
      send(1'b0, 8'd255, 25'h0800000, 3'b000, mk(32'h7F800000, 1, 0, 2), 1, 1);
   endtask

   task automatic test_underflow();
      send(1'b0, 8'd3, 25'h0000001, 3'b000, mk(32'h00000000, 0, 1, 5), 1, 1);
      send(1'b1, 8'd0, 25'h0800000, 3'b000, mk(32'h80000000, 0, 1, 2), 1, 1);
   endtask

   task automatic test_back_to_back();
      logic        s;
      logic [7:0]  e;
      logic [24:0] m;
      logic [2:0]  g;
      int          p, sh;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         g = 3'($urandom_range(0, 7));
         e = 8'($urandom_range(1, 254));
         if (i % 2 == 0) m = {1'b1, 24'($urandom)};
         else            m = {2'b01, 23'($urandom)};
         send(s, e, m, g, model_norm(s, e, m, g), 1, 1);
      end
      for (int i = 0; i < 12; i++) begin
         s  = 1'($urandom_range(0, 1));
         p  = $urandom_range(0, 22);
         m  = 25'((1 << p) | (int'($urandom) & ((1 << p) - 1)));
         sh = 23 - p;
         e  = 8'($urandom_range(30, 254));
         send(s, e, m, 3'b000,
              mk({s, 8'(int'(e) - sh), 23'(int'(m) << sh)}, 0, 0, 3 + sh), 1, 1);
      end
   endtask

   task automatic test_backpressure();
      int t;
      out_ready = 1'b0;
      send(1'b0, 8'd127, 25'h1000000, 3'b000, mk(32'h40000000, 0, 0, 3), 1, 0);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL hold_valid_timeout: out_valid=%b, expected 1", out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (result !== 32'h40000000 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
             overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: res=%h ov=%b ir=%b, expected 40000000 1 0",
                     result, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      int outs;
      send(1'b0, 8'd150, 25'h0000001, 3'b000, '0, 0, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (debug_state !== 3'd2) begin
         errors++;
         $display("FAIL shift_state: state=%0d, expected 2", debug_state);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || debug_state !== 3'd0) begin
         errors++;
         $display("FAIL abort_async: ov=%b ir=%b st=%0d, expected 0 0 0", out_valid, in_ready, debug_state);
      end
      @(posedge clk);
      #1;
      checks++;
      if (result !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear: res=%h ovf=%b unf=%b, expected 0 0 0", result, overflow, underflow);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_release: in_ready=%b, expected 1", in_ready);
      end
      outs = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) outs++;
      end
      checks++;
      if (outs != 0) begin
         errors++;
         $display("FAIL abort_no_output: %0d valid cycles, expected 0", outs);
      end
      send(1'b0, 8'd127, 25'h0800000, 3'b000, mk(32'h3F800000, 0, 0, 3), 1, 1);
   endtask

   // Test sequence and final report.
   initial begin
      test_reset();
      test_normalize();
      test_round();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_shift();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
